// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard unit: forwarding, load/branch/divide stalls, flush control
module hazard_scoreboard #(
    parameter int REGW       = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REGW-1:0]  rsD,
    input  logic [REGW-1:0]  rtD,
    input  logic             branchD,
    input  logic [REGW-1:0]  rsE,
    input  logic [REGW-1:0]  rtE,
    input  logic [REGW-1:0]  writeregE,
    input  logic             regwriteE,
    input  logic             memtoregE,
    input  logic             divE,
    input  logic [REGW-1:0]  writeregM,
    input  logic             regwriteM,
    input  logic             memtoregM,
    input  logic [REGW-1:0]  writeregW,
    input  logic             regwriteW,
    input  logic             exc_flush,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       forwardaD,
    output logic [1:0]       forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             div_start,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    localparam logic [7:0] LAST = 8'(DIV_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       lwstall;
    logic       brstall;
    logic       divstall;

    // M result is newer than W, so it wins when both match
    function automatic logic [1:0] fwdSel(input logic [REGW-1:0] src,
                                          input logic [REGW-1:0] wrM, input logic wenM,
                                          input logic [REGW-1:0] wrW, input logic wenW);
        if (src != '0 && wenM && wrM == src)
            return 2'b10;
        else if (src != '0 && wenW && wrW == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forwardaD = fwdSel(rsD, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardbD = fwdSel(rtD, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardaE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardbE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);

    assign lwstall  = memtoregE && rtE != '0 && (rtE == rsD || rtE == rtD);
    assign brstall  = branchD &&
                      ((regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
                       (memtoregM && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));
    assign divstall = divE && state != DONE;
    assign div_busy = state != IDLE;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
        if (!exc_flush) begin
            stallE = divstall;
            stallD = divstall | lwstall | brstall;
            stallF = divstall | lwstall | brstall;
            flushD = 1'b0;
            // a held divide in E must not be replaced by a bubble
            flushE = (lwstall | brstall) & ~divstall;
            flushM = divstall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            div_start <= 1'b0;
        end else begin
            div_start <= 1'b0;
            if (exc_flush) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else begin
                case (state)
                    IDLE: if (divE) begin
                        state     <= BUSY;
                        cnt       <= 8'd0;
                        div_start <= 1'b1;
                    end
                    BUSY: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == LAST)
                            state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stallF && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int REGW = 5;
    localparam int DC   = 4;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst;
    logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW, exc_flush;
    logic stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE;
    logic div_start, div_busy;
    logic [CW-1:0] stall_count;

    int errors = 0;
    int checks = 0;
    int pos;
    int mcount;

    hazard_scoreboard #(.REGW(REGW), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .exc_flush(exc_flush),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .div_start(div_start), .div_busy(div_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic clearInputs;
        rsD = '0; rtD = '0; branchD = 0; rsE = '0; rtE = '0; writeregE = '0;
        regwriteE = 0; memtoregE = 0; divE = 0; writeregM = '0; regwriteM = 0;
        memtoregM = 0; writeregW = '0; regwriteW = 0; exc_flush = 0;
    endtask

    task automatic doReset;
        clearInputs();
        rst = 1;
        settle();
        tick();
        rst = 0;
    endtask

    function automatic logic [1:0] refFwd(int src, int wm, bit rm, int ww, bit rw);
        if (src != 0 && rm && wm == src) return 2'b10;
        if (src != 0 && rw && ww == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset;
        clearInputs();
        rst = 1;
        divE = 1;
        #3;
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", div_busy); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", div_start); end
        checks++; if (stallE !== 1'b1) begin errors++; $display("FAIL reset_comb_stallE got=%b exp=1", stallE); end
        tick();
        rst = 0;
        divE = 0;
    endtask

    task automatic test_forwarding;
        clearInputs();
        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        #1;
        checks++; if (forwardaE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got=%b exp=10", forwardaE); end
        rsE = 0;
        #1;
        checks++; if (forwardaE !== 2'b00) begin errors++; $display("FAIL fwd_r0 got=%b exp=00", forwardaE); end
        rsE = 3; regwriteM = 0;
        #1;
        checks++; if (forwardaE !== 2'b01) begin errors++; $display("FAIL fwd_w got=%b exp=01", forwardaE); end
        rtD = 7; writeregW = 7;
        #1;
        checks++; if (forwardbD !== 2'b01) begin errors++; $display("FAIL fwd_bD_w got=%b exp=01", forwardbD); end
        clearInputs();
    endtask

    task automatic test_lwstall;
        doReset();
        memtoregE = 1; rtE = 5; rsD = 5;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if ({stallF, stallD, flushE, stallE} !== 4'b1110)
                begin errors++; $display("FAIL lw_ctrl cyc=%0d got=%b exp=1110", k, {stallF, stallD, flushE, stallE}); end
            checks++; if (stall_count !== CW'(k))
                begin errors++; $display("FAIL lw_count cyc=%0d got=%0d exp=%0d", k, stall_count, k); end
            tick();
        end
        clearInputs();
        settle();
        checks++; if (stall_count !== CW'(3)) begin errors++; $display("FAIL lw_count_end got=%0d exp=3", stall_count); end
        tick();
    endtask

    task automatic checkDivPhase(int c, int p);
        bit st;
        st = (p <= DC + 1) && p != DC + 2 && p != DC + 2;
        st = p <= DC + 1;
        checks++; if (stallE !== st || stallF !== st)
            begin errors++; $display("FAIL div_stall c=%0d got=%b%b exp=%b", c, stallE, stallF, st); end
        checks++; if (div_start !== (p == 2))
            begin errors++; $display("FAIL div_start c=%0d got=%b exp=%b", c, div_start, p == 2); end
        checks++; if (div_busy !== (p >= 2))
            begin errors++; $display("FAIL div_busy c=%0d got=%b exp=%b", c, div_busy, p >= 2); end
        checks++; if (flushE !== 1'b0 || flushM !== st)
            begin errors++; $display("FAIL div_flush c=%0d got=%b%b exp=0%b", c, flushE, flushM, st); end
    endtask

    task automatic test_divide;
        doReset();
        divE = 1;
        for (int c = 1; c <= DC + 2; c++) begin
            settle();
            checkDivPhase(c, c);
            if (c == DC + 2) begin
                checks++; if (stall_count !== CW'(DC + 1))
                    begin errors++; $display("FAIL div_count got=%0d exp=%0d", stall_count, DC + 1); end
            end
            tick();
        end
        divE = 0;
        tick();
    endtask

    task automatic test_back_to_back;
        doReset();
        divE = 1;
        for (int c = 1; c <= 2 * (DC + 2); c++) begin
            settle();
            checkDivPhase(c, (c - 1) % (DC + 2) + 1);
            tick();
        end
        divE = 0;
        tick();
    endtask

    task automatic test_exc_flush;
        doReset();
        divE = 1;
        for (int c = 1; c <= 3; c++) begin settle(); tick(); end
        exc_flush = 1;
        settle();
        checks++; if ({flushD, flushE, flushM} !== 3'b111)
            begin errors++; $display("FAIL exc_flush got=%b exp=111", {flushD, flushE, flushM}); end
        checks++; if ({stallF, stallD, stallE} !== 3'b000)
            begin errors++; $display("FAIL exc_stall got=%b exp=000", {stallF, stallD, stallE}); end
        tick();
        exc_flush = 0;
        settle();
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL exc_busy got=%b exp=0", div_busy); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL exc_start got=%b exp=0", div_start); end
        checks++; if (stallF !== 1'b1) begin errors++; $display("FAIL exc_restall got=%b exp=1", stallF); end
        tick();
        clearInputs();
    endtask

    task automatic test_async_reset;
        doReset();
        divE = 1;
        tick(); tick(); tick();
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got=%b exp=1", div_busy); end
        #2 rst = 1;
        #1;
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", div_busy); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL arst_count got=%0d exp=0", stall_count); end
        #2 rst = 0;
        #1;
        checks++; if (stallF !== 1'b1 || div_busy !== 1'b0)
            begin errors++; $display("FAIL arst_idle got=%b%b exp=10", stallF, div_busy); end
        tick();
        checks++; if (div_start !== 1'b1 || div_busy !== 1'b1)
            begin errors++; $display("FAIL arst_restart got=%b%b exp=11", div_start, div_busy); end
        clearInputs();
        tick();
    endtask

    task automatic test_saturation;
        doReset();
        memtoregE = 1; rtE = 5; rsD = 5;
        for (int c = 0; c < 20; c++) tick();
        settle();
        checks++; if (stall_count !== CW'(15)) begin errors++; $display("FAIL sat_count got=%0d exp=15", stall_count); end
        clearInputs();
        tick();
    endtask

    task automatic test_random;
        bit lw, br, ds, eF, eD, eE, fD, fE, fM;
        doReset();
        pos = 0;
        mcount = 0;
        for (int n = 0; n < 400; n++) begin
            rsD = REGW'($urandom_range(0, 3)); rtD = REGW'($urandom_range(0, 3));
            rsE = REGW'($urandom_range(0, 3)); rtE = REGW'($urandom_range(0, 3));
            writeregE = REGW'($urandom_range(0, 3)); writeregM = REGW'($urandom_range(0, 3));
            writeregW = REGW'($urandom_range(0, 3));
            branchD = $urandom_range(0, 1) == 1; regwriteE = $urandom_range(0, 1) == 1;
            memtoregE = $urandom_range(0, 3) == 0; regwriteM = $urandom_range(0, 1) == 1;
            memtoregM = $urandom_range(0, 3) == 0; regwriteW = $urandom_range(0, 1) == 1;
            divE = $urandom_range(0, 2) == 0; exc_flush = $urandom_range(0, 24) == 0;
            lw = memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD);
            br = branchD && ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                             (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
            ds = divE && pos != DC + 1;
            if (exc_flush) begin
                {eF, eD, eE, fD, fE, fM} = 6'b000111;
            end else begin
                eE = ds; eF = ds | lw | br; eD = eF;
                fD = 0; fE = (lw | br) & !ds; fM = ds;
            end
            settle();
            checks++; if ({stallF, stallD, stallE, flushD, flushE, flushM} !== {eF, eD, eE, fD, fE, fM})
                begin errors++; $display("FAIL rnd_ctrl n=%0d got=%b exp=%b", n,
                    {stallF, stallD, stallE, flushD, flushE, flushM}, {eF, eD, eE, fD, fE, fM}); end
            checks++; if ({forwardaD, forwardbD, forwardaE, forwardbE} !==
                          {refFwd(rsD, writeregM, regwriteM, writeregW, regwriteW),
                           refFwd(rtD, writeregM, regwriteM, writeregW, regwriteW),
                           refFwd(rsE, writeregM, regwriteM, writeregW, regwriteW),
                           refFwd(rtE, writeregM, regwriteM, writeregW, regwriteW)})
                begin errors++; $display("FAIL rnd_fwd n=%0d got=%b", n, {forwardaD, forwardbD, forwardaE, forwardbE}); end
            checks++; if (div_busy !== (pos != 0) || div_start !== (pos == 1))
                begin errors++; $display("FAIL rnd_div n=%0d got=%b%b pos=%0d", n, div_busy, div_start, pos); end
            checks++; if (stall_count !== CW'(mcount))
                begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, stall_count, mcount); end
            tick();
            if (eF && mcount < 15) mcount++;
            if (exc_flush) pos = 0;
            else if (pos == 0) pos = divE ? 1 : 0;
            else if (pos == DC + 1) pos = 0;
            else pos++;
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst = 0;
        test_reset();
        test_forwarding();
        test_lwstall();
        test_divide();
        test_back_to_back();
        test_exc_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REGW, 5, register-index width; register 0 is hardwired zero.
REQ-002 Parameter DIV_CYCLES, 32, divider busy cycles, legal range 2..255.
REQ-003 Parameter CNT_W, 32, stall performance-counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rsD, rtD  in  REGW  decode source registers; branchD  in  1  branch in D.
REQ-007 rsE, rtE, writeregE  in  REGW  execute sources and destination.
REQ-008 regwriteE, memtoregE, divE  in  1  E writes reg, E is load, E is div/divu.
REQ-009 writeregM  in  REGW; regwriteM, memtoregM  in  1  memory-stage destination info.
REQ-010 writeregW  in  REGW; regwriteW  in  1  writeback destination info.
REQ-011 exc_flush  in  1  exception/eret redirect; kills F/D/E/M contents.
REQ-012 stallF, stallD, stallE  out  1  hold the corresponding pipeline register.
REQ-013 flushD, flushE, flushM  out  1  load a bubble into the corresponding pipeline register.
REQ-014 forwardaD, forwardbD  out  2  branch-compare mux: 00 regfile, 10 from M, 01 from W.
REQ-015 forwardaE, forwardbE  out  2  ALU mux: 00 regfile, 10 from M, 01 from W.
REQ-016 div_start  out  1  one-cycle pulse launching the divider datapath.
REQ-017 div_busy  out  1  divider FSM not IDLE.
REQ-018 stall_count  out  CNT_W  number of cycles stallF was high.

Function
REQ-019 Forwarding: a source is matched only if nonzero; M match has priority over W; matches require the respective regwrite.
REQ-020 Forwarding outputs shall be purely combinational from current inputs.
REQ-021 lwstall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
REQ-022 brstall = branchD & ((regwriteE & writeregE!=0 & writeregE matches rsD/rtD) | (memtoregM & writeregM!=0 & writeregM matches rsD/rtD)).
REQ-023 Divider FSM states: IDLE, BUSY, DONE; 8-bit counter cnt.
REQ-024 IDLE -> BUSY when divE & ~exc_flush; cnt<=0; div_start high for the first BUSY cycle only.
REQ-025 BUSY: cnt increments each cycle; BUSY -> DONE when cnt==DIV_CYCLES-1.
REQ-026 DONE -> IDLE unconditionally after one cycle.
REQ-027 divstall = divE & (state!=DONE); a div therefore stalls exactly DIV_CYCLES+1 cycles and advances in DONE.
REQ-028 Back-to-back divides: second div reaches E after DONE->IDLE and restarts the full sequence.
REQ-029 stallE = divstall; stallD = stallF = divstall | lwstall | brstall.
REQ-030 flushE = (lwstall | brstall) & ~divstall; E is never flushed while holding a stalled div.
REQ-031 flushM = divstall, so M receives bubbles during divide.
REQ-032 flushD = 0 except on exception.
REQ-033 exc_flush overrides everything combinationally: flushD=flushE=flushM=1 and all stalls 0.
REQ-034 exc_flush in any FSM state forces IDLE and cnt=0 next edge; no div_start pulse that cycle.
REQ-035 stall_count increments each cycle stallF=1; it saturates at all-ones and never wraps.

Reset
REQ-036 On rst high, regardless of clk: FSM=IDLE, cnt=0, div_start=0, stall_count=0.
REQ-037 During reset, combinational outputs follow REQ-019..033 with div_busy=0.
REQ-038 Reset asserted mid-divide aborts it; first cycle after release behaves as IDLE.

Verification
REQ-039 rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardaE=10; rsE=0 with same -> 00.
REQ-040 memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=1, flushE=1, stallE=0; stall_count +1 per cycle.
REQ-041 divE=1 held, DIV_CYCLES=4 -> 5 stall cycles, div_start one pulse in cycle 2, stallE=0 in cycle 6, flushE=0 throughout.
REQ-042 exc_flush pulse at BUSY cnt=2 -> flushD/E/M=1, stalls 0 that cycle, div_busy=0 next cycle.
REQ-043 rst asserted asynchronously between edges during BUSY -> div_busy, stall_count 0 immediately.
REQ-044 CNT_W=4, stall held 20 cycles -> stall_count sticks at 15.
